conv1_sched: RTL

CONV1_SCHED -- requirements
Module: conv1_sched

---
 rtl/conv1_sched.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/conv1_sched.sv
// conv1_sched: per-channel sequencer for the conv1 engine. For each of NUM_CH
// channels it loads a 5x5 weight window and a bias from 1-cycle-latency ROMs,
// releases the engine, and waits until both the conv and maxpool beat counts
// are complete before moving to the next channel.
// Optional feature macro: CONV1_SCHED_WATCHDOG_EN adds the err output and an
// idle-cycle watchdog in RUN that aborts the run after TIMEOUT silent cycles.
module conv1_sched #(
  parameter int unsigned NUM_CH   = 6,
  parameter int unsigned CONV_CNT = 784,
  parameter int unsigned POOL_CNT = 196,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        wrom_addr,
  input  logic signed [8:0] wrom_data,
  output logic [2:0]        brom_addr,
  input  logic signed [8:0] brom_data,
  output logic [44:0]       weight_m_1,
  output logic [44:0]       weight_m_2,
  output logic [44:0]       weight_m_3,
  output logic [44:0]       weight_m_4,
  output logic [44:0]       weight_m_5,
  output logic signed [8:0] bias,
  output logic              eng_rstn,
  input  logic              conv_valid,
  input  logic              maxpool_valid,
  output logic [2:0]        ch_idx,
  output logic              ch_done
`ifdef CONV1_SCHED_WATCHDOG_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned LD_W    = 5;
  localparam int unsigned KSZ     = 5;
  localparam int unsigned WIN     = 25;
  localparam int unsigned LD_LAST = 25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic              ch_done_q;
  logic              eng_rstn_q;
  logic [2:0]        ch_q;
  logic [7:0]        wrom_addr_q;
  logic [2:0]        brom_addr_q;
  logic [44:0]       wm_q [KSZ];
  logic signed [8:0] bias_q;
  logic [LD_W-1:0]   ld_cnt_q;
  logic [2:0]        col_q;
  logic [CNT_W-1:0]  conv_cnt_q;
  logic [CNT_W-1:0]  conv_cnt_d;
  logic [CNT_W-1:0]  pool_cnt_q;
  logic [CNT_W-1:0]  pool_cnt_d;
  logic              conv_full_c;
  logic              pool_full_c;
  logic              last_ch_c;
  logic [2:0]        ch_nxt_c;

`ifdef CONV1_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            silent_c;
  assign silent_c = !(conv_valid || maxpool_valid);
  assign err      = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  // Saturating next beat counts and channel bookkeeping
  always_comb begin
    conv_cnt_d = conv_cnt_q;
    pool_cnt_d = pool_cnt_q;
    if (conv_valid && (conv_cnt_q != CNT_W'(CONV_CNT))) begin
      conv_cnt_d = conv_cnt_q + CNT_W'(1);
    end
    if (maxpool_valid && (pool_cnt_q != CNT_W'(POOL_CNT))) begin
      pool_cnt_d = pool_cnt_q + CNT_W'(1);
    end
    conv_full_c = (conv_cnt_d == CNT_W'(CONV_CNT));
    pool_full_c = (pool_cnt_d == CNT_W'(POOL_CNT));
    ch_nxt_c    = ch_q + 3'd1;
    last_ch_c   = ((32'(ch_q) + 32'd1) >= NUM_CH);
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ch_done_q   <= 1'b0;
      eng_rstn_q  <= 1'b0;
      ch_q        <= '0;
      wrom_addr_q <= '0;
      brom_addr_q <= '0;
      wm_q        <= '{default: '0};
      bias_q      <= '0;
      ld_cnt_q    <= '0;
      col_q       <= '0;
      conv_cnt_q  <= '0;
      pool_cnt_q  <= '0;
`ifdef CONV1_SCHED_WATCHDOG_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      ch_done_q <= 1'b0;
`ifdef CONV1_SCHED_WATCHDOG_EN
      if (state_q != S_RUN) wd_q <= '0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            busy_q      <= 1'b1;
            ch_q        <= '0;
            wrom_addr_q <= '0;
            brom_addr_q <= '0;
            ld_cnt_q    <= '0;
            col_q       <= '0;
`ifdef CONV1_SCHED_WATCHDOG_EN
            err_q       <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          // ROM data arriving in cycle k belongs to the address issued in k-1
          ld_cnt_q <= ld_cnt_q + LD_W'(1);
          if (ld_cnt_q < LD_W'(LD_LAST - 1)) wrom_addr_q <= wrom_addr_q + 8'd1;
          if (ld_cnt_q == LD_W'(1)) bias_q <= brom_data;
          if (ld_cnt_q != '0) begin
            // Row-major weights: each column register shifts in one row, row 0 ends in the MSBs
            wm_q[col_q] <= {wm_q[col_q][35:0], wrom_data};
            col_q       <= (col_q == 3'(KSZ - 1)) ? 3'd0 : col_q + 3'd1;
          end
          if (ld_cnt_q == LD_W'(LD_LAST)) begin
            state_q    <= S_RUN;
            eng_rstn_q <= 1'b1;
            conv_cnt_q <= '0;
            pool_cnt_q <= '0;
          end
        end
        S_RUN: begin
          conv_cnt_q <= conv_cnt_d;
          pool_cnt_q <= pool_cnt_d;
          if (conv_full_c && pool_full_c) begin
            state_q    <= S_NEXT;
            eng_rstn_q <= 1'b0;
            ch_done_q  <= 1'b1;
          end
`ifdef CONV1_SCHED_WATCHDOG_EN
          else if (silent_c) begin
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              eng_rstn_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              wd_q <= wd_q + WD_W'(1);
            end
          end else begin
            wd_q <= '0;
          end
`endif
        end
        S_NEXT: begin
          if (last_ch_c) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q     <= S_LOAD;
            ch_q        <= ch_nxt_c;
            wrom_addr_q <= 8'(ch_nxt_c) * 8'(WIN);
            brom_addr_q <= ch_nxt_c;
            ld_cnt_q    <= '0;
            col_q       <= '0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          eng_rstn_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ch_done    = ch_done_q;
  assign eng_rstn   = eng_rstn_q;
  assign ch_idx     = ch_q;
  assign wrom_addr  = wrom_addr_q;
  assign brom_addr  = brom_addr_q;
  assign weight_m_1 = wm_q[0];
  assign weight_m_2 = wm_q[1];
  assign weight_m_3 = wm_q[2];
  assign weight_m_4 = wm_q[3];
  assign weight_m_5 = wm_q[4];
  assign bias       = bias_q;

endmodule
